layer_sequencer: RTL and testbench

- Hardware replacement for the testbench's per-layer run sequence (conv1..conv5) in front of the accelerator core.
- Holds up to MAX_LAYERS layer configuration descriptors written by the host.
- On `run`, for each layer in turn: serially shifts the descriptor into the core's configuration scan chain, pulses load, pulses core start and waits for core done.
- Reports a per-layer cycle count, then signals completion.

---
 rtl/layer_pkg.sv | 37 +++
 rtl/scan_serializer.sv | 51 +++++
 rtl/layer_sequencer.sv | 143 ++++++++++++++
 tb/tb_layer_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_pkg.sv
// layer_pkg: shared constants, FSM states and conv1..conv5 descriptor layout for the layer sequencer
package layer_pkg;
    localparam int MAX_LAYERS_DEF = 5;
    localparam int CFG_W_DEF      = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_FIN
    } state_e;

    // flags: bit0 relu, bit1 max-pool after the layer
    typedef struct packed {
        logic [7:0]  flags;
        logic [3:0]  pad;
        logic [3:0]  stride;
        logic [3:0]  kernel;
        logic [9:0]  in_w;
        logic [9:0]  in_h;
        logic [11:0] out_ch;
        logic [11:0] in_ch;
    } layer_cfg_t;

    localparam layer_cfg_t CONV1_CFG = '{flags: 8'h03, pad: 4'd0, stride: 4'd4, kernel: 4'd11,
                                         in_w: 10'd227, in_h: 10'd227, out_ch: 12'd96, in_ch: 12'd3};
    localparam layer_cfg_t CONV2_CFG = '{flags: 8'h03, pad: 4'd2, stride: 4'd1, kernel: 4'd5,
                                         in_w: 10'd27, in_h: 10'd27, out_ch: 12'd256, in_ch: 12'd96};
    localparam layer_cfg_t CONV3_CFG = '{flags: 8'h01, pad: 4'd1, stride: 4'd1, kernel: 4'd3,
                                         in_w: 10'd13, in_h: 10'd13, out_ch: 12'd384, in_ch: 12'd256};
    localparam layer_cfg_t CONV4_CFG = '{flags: 8'h01, pad: 4'd1, stride: 4'd1, kernel: 4'd3,
                                         in_w: 10'd13, in_h: 10'd13, out_ch: 12'd384, in_ch: 12'd384};
    localparam layer_cfg_t CONV5_CFG = '{flags: 8'h03, pad: 4'd1, stride: 4'd1, kernel: 4'd3,
                                         in_w: 10'd13, in_h: 10'd13, out_ch: 12'd256, in_ch: 12'd384};
endpackage

// File: rtl/scan_serializer.sv
// scan_serializer: shifts a loaded descriptor out LSB first over CFG_W cycles, flagging the last bit
module scan_serializer
    import layer_pkg::*;
#(
    parameter int CFG_W = CFG_W_DEF
) (
    input  logic             core_clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CFG_W-1:0] data,
    output logic             scan_en,
    output logic             scan_data,
    output logic             last
);
    localparam int CW = $clog2(CFG_W);

    logic [CFG_W-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             en_q, en_d;

    assign last      = en_q && cnt_q == CW'(CFG_W - 1);
    assign scan_en   = en_q;
    assign scan_data = en_q & sr_q[0];

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        en_d  = en_q;
        if (load) begin
            sr_d  = data;
            cnt_d = '0;
            en_d  = 1'b1;
        end else if (en_q) begin
            sr_d  = sr_q >> 1;
            cnt_d = last ? '0 : cnt_q + CW'(1);
            en_d  = !last;
        end
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            en_q  <= en_d;
        end
    end
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: runs up to MAX_LAYERS descriptors through scan-load, core start and done, timing each layer
module layer_sequencer
    import layer_pkg::*;
#(
    parameter int MAX_LAYERS = MAX_LAYERS_DEF,
    parameter int CFG_W      = CFG_W_DEF,
    parameter int CNT_W      = 32
) (
    input  logic                            core_clk,
    input  logic                            rst_n,
    input  logic                            cfg_wr_en,
    input  logic [$clog2(MAX_LAYERS)-1:0]   cfg_wr_addr,
    input  logic [CFG_W-1:0]                cfg_wr_data,
    input  logic [$clog2(MAX_LAYERS+1)-1:0] num_layers,
    input  logic                            run,
    output logic                            busy,
    output logic                            scan_en,
    output logic                            scan_data,
    output logic                            scan_load,
    output logic                            core_start,
    input  logic                            core_done,
    output logic [$clog2(MAX_LAYERS)-1:0]   layer_idx,
    output logic                            layer_done,
    output logic [CNT_W-1:0]                layer_cycles,
    output logic                            all_done,
    output logic                            err
);
    localparam int IW = $clog2(MAX_LAYERS);
    localparam int NW = $clog2(MAX_LAYERS + 1);

    state_e           state_q, state_d;
    logic [CFG_W-1:0] desc_q [MAX_LAYERS];
    logic [CFG_W-1:0] desc_d [MAX_LAYERS];
    logic [NW-1:0]    num_q, num_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cyc_q, cyc_d, cnt_inc;
    logic             ldone_q, ldone_d, adone_q, adone_d, err_q, err_d;
    logic [NW:0]      idx_next;
    logic             more, shift_last, ser_load;

    assign cnt_inc  = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
    assign idx_next = (NW+1)'(idx_q) + (NW+1)'(1);
    assign more     = idx_next < {1'b0, num_q};
    // the serializer loads on every entry into SHIFT, using post-write contents so a same-cycle write is shifted
    assign ser_load = state_d == ST_SHIFT && state_q != ST_SHIFT;

    always_comb begin
        state_d = state_q;
        desc_d  = desc_q;
        num_d   = num_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        ldone_d = 1'b0;
        adone_d = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    if (num_layers == '0) begin
                        adone_d = 1'b1;
                    end else if (int'(num_layers) > MAX_LAYERS) begin
                        err_d = 1'b1;
                    end else begin
                        num_d   = num_layers;
                        idx_d   = '0;
                        err_d   = 1'b0;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: state_d = shift_last ? ST_LOAD : ST_SHIFT;
            ST_LOAD:  state_d = ST_START;
            ST_START: begin
                cnt_d   = CNT_W'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                if (core_done) begin
                    cyc_d   = cnt_inc;
                    ldone_d = 1'b1;
                    idx_d   = more ? idx_next[IW-1:0] : idx_q;
                    state_d = more ? ST_SHIFT : ST_FIN;
                end
            end
            ST_FIN: begin
                adone_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // error sources are applied after the run-accept clear so they win in the same cycle
        if (cfg_wr_en) begin
            if (state_q != ST_IDLE || int'(cfg_wr_addr) >= MAX_LAYERS) err_d = 1'b1;
            else desc_d[cfg_wr_addr] = cfg_wr_data;
        end
        if (core_done && state_q != ST_WAIT) err_d = 1'b1;
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            desc_q  <= '{default: '0};
            num_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            cyc_q   <= '0;
            ldone_q <= 1'b0;
            adone_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            desc_q  <= desc_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            ldone_q <= ldone_d;
            adone_q <= adone_d;
            err_q   <= err_d;
        end
    end

    scan_serializer #(.CFG_W(CFG_W)) u_ser (
        .core_clk  (core_clk),
        .rst_n     (rst_n),
        .load      (ser_load),
        .data      (desc_d[idx_d]),
        .scan_en   (scan_en),
        .scan_data (scan_data),
        .last      (shift_last)
    );

    assign busy         = state_q != ST_IDLE;
    assign scan_load    = state_q == ST_LOAD;
    assign core_start   = state_q == ST_START;
    assign layer_idx    = idx_q;
    assign layer_done   = ldone_q;
    assign layer_cycles = cyc_q;
    assign all_done     = adone_q;
    assign err          = err_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed scenarios against hand-computed scan bits, pulse cycles and layer counts
module tb_layer_sequencer;
    import layer_pkg::*;

    logic        core_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_wr_en = 1'b0;
    logic [2:0]  cfg_wr_addr = '0;
    logic [63:0] cfg_wr_data = '0;
    logic [2:0]  num_layers = '0;
    logic        run = 1'b0;
    logic        core_done = 1'b0;
    logic        busy, scan_en, scan_data, scan_load, core_start, layer_done, all_done, err;
    logic [2:0]  layer_idx;
    logic [31:0] layer_cycles;
    logic        s_busy, s_scan_en, s_scan_data, s_scan_load, s_core_start, s_layer_done, s_all_done, s_err;
    logic [2:0]  s_layer_idx;
    logic [3:0]  s_layer_cycles;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] obs_bits [5];
    int          obs_en [5];
    logic [31:0] obs_cyc [5];
    logic [2:0]  obs_sidx [5];
    int          lat_tab [5];
    int          ndone, nall, all_cycle, done_cycle, first_load, first_start;
    logic        obs_err5;
    bit          rst_hit;
    int          inj_wr_cycle = -1;
    logic [2:0]  inj_addr = '0;
    logic [63:0] inj_data = '0;
    bit          inj_rst = 1'b0;

    always #5 core_clk = ~core_clk;

    layer_sequencer dut (
        .core_clk(core_clk), .rst_n(rst_n), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_data(cfg_wr_data), .num_layers(num_layers), .run(run), .busy(busy), .scan_en(scan_en),
        .scan_data(scan_data), .scan_load(scan_load), .core_start(core_start), .core_done(core_done),
        .layer_idx(layer_idx), .layer_done(layer_done), .layer_cycles(layer_cycles),
        .all_done(all_done), .err(err)
    );

    layer_sequencer #(.CNT_W(4)) dut_sat (
        .core_clk(core_clk), .rst_n(rst_n), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_data(cfg_wr_data), .num_layers(num_layers), .run(run), .busy(s_busy), .scan_en(s_scan_en),
        .scan_data(s_scan_data), .scan_load(s_scan_load), .core_start(s_core_start), .core_done(core_done),
        .layer_idx(s_layer_idx), .layer_done(s_layer_done), .layer_cycles(s_layer_cycles),
        .all_done(s_all_done), .err(s_err)
    );

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    task automatic write_cfg(input logic [2:0] a, input logic [63:0] d);
        cfg_wr_en = 1'b1;
        cfg_wr_addr = a;
        cfg_wr_data = d;
        step();
        cfg_wr_en = 1'b0;
    endtask

    // drives run, plays the core (done lat_tab[k] cycles after the k-th start) and records what it sees; cycle 1 follows the accept edge
    task automatic run_seq(input int n);
        int c, done_at, started;
        bit fin;
        c = 0; done_at = -1; started = 0; fin = 0;
        ndone = 0; nall = 0; all_cycle = -1; done_cycle = -1; first_load = -1; first_start = -1;
        rst_hit = 0; obs_err5 = 1'bx;
        for (int i = 0; i < 5; i++) begin
            obs_bits[i] = '0; obs_en[i] = 0; obs_cyc[i] = '0; obs_sidx[i] = '0;
        end
        num_layers = 3'(n);
        run = 1'b1;
        step();
        c = 1;
        run = 1'b0;
        cfg_wr_en = 1'b0;
        while (!fin) begin
            if (inj_rst && layer_idx == 3'd1 && scan_en && obs_en[1] == 30) begin
                rst_n = 1'b0;
                core_done = 1'b0;
                rst_hit = 1;
                fin = 1;
            end else begin
                if (scan_en && layer_idx < 3'd5) begin
                    if (obs_en[layer_idx] < 64) obs_bits[layer_idx][obs_en[layer_idx]] = scan_data;
                    obs_en[layer_idx]++;
                end
                if (scan_load && first_load < 0) first_load = c;
                if (core_start) begin
                    if (first_start < 0) first_start = c;
                    if (started < 5) begin
                        obs_sidx[started] = layer_idx;
                        done_at = c + lat_tab[started];
                    end
                    started++;
                end
                if (layer_done) begin
                    if (ndone < 5) obs_cyc[ndone] = layer_cycles;
                    done_cycle = c;
                    ndone++;
                end
                if (all_done) begin
                    nall++;
                    if (all_cycle < 0) all_cycle = c;
                end
                if (c == 5) obs_err5 = err;
                core_done = (c == done_at);
                cfg_wr_en = (c == inj_wr_cycle);
                if (c == inj_wr_cycle) begin
                    cfg_wr_addr = inj_addr;
                    cfg_wr_data = inj_data;
                end
                step();
                c++;
                if (all_cycle >= 0 && c > all_cycle + 3) fin = 1;
                else if (c > 3000) fin = 1;
            end
        end
        core_done = 1'b0;
        cfg_wr_en = 1'b0;
        n_cmp++;
        if (all_cycle < 0 && !rst_hit) begin
            n_bad++;
            $display("FAIL seq_timeout: no all_done within 3000 cycles (layers=%0d)", n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_cmp++; if ({busy, scan_en, scan_data, scan_load, core_start, layer_done, all_done, err} !== 8'h0) begin
            n_bad++; $display("FAIL reset_flags got=%b exp=0", {busy, scan_en, scan_data, scan_load, core_start, layer_done, all_done, err}); end
        n_cmp++; if (layer_idx !== 3'd0) begin n_bad++; $display("FAIL reset_idx got=%0d exp=0", layer_idx); end
        n_cmp++; if (layer_cycles !== 32'd0) begin n_bad++; $display("FAIL reset_cycles got=%0d exp=0", layer_cycles); end
        n_cmp++; if ({s_busy, s_scan_en, s_scan_data, s_scan_load, s_core_start, s_layer_done, s_all_done, s_err, s_layer_idx, s_layer_cycles} !== 15'h0) begin
            n_bad++; $display("FAIL reset_sat_outputs got=%h exp=0",
                {s_busy, s_scan_en, s_scan_data, s_scan_load, s_core_start, s_layer_done, s_all_done, s_err, s_layer_idx, s_layer_cycles}); end
        step();
        step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        lat_tab[0] = 10;
        cfg_wr_en = 1'b1;
        cfg_wr_addr = 3'd0;
        cfg_wr_data = 64'h5;
        run_seq(1);
        n_cmp++; if (obs_bits[0] !== 64'h5) begin n_bad++; $display("FAIL single_bits got=%h exp=5", obs_bits[0]); end
        n_cmp++; if (obs_en[0] !== 64) begin n_bad++; $display("FAIL single_scan_en got=%0d exp=64", obs_en[0]); end
        n_cmp++; if (first_load !== 65) begin n_bad++; $display("FAIL single_load_cycle got=%0d exp=65", first_load); end
        n_cmp++; if (first_start !== 66) begin n_bad++; $display("FAIL single_start_cycle got=%0d exp=66", first_start); end
        n_cmp++; if (obs_cyc[0] !== 32'd11) begin n_bad++; $display("FAIL single_cycles got=%0d exp=11", obs_cyc[0]); end
        n_cmp++; if (done_cycle !== 77) begin n_bad++; $display("FAIL single_done_cycle got=%0d exp=77", done_cycle); end
        n_cmp++; if (all_cycle !== 78) begin n_bad++; $display("FAIL single_all_cycle got=%0d exp=78", all_cycle); end
        n_cmp++; if (nall !== 1 || ndone !== 1) begin n_bad++; $display("FAIL single_pulses got=%0d/%0d exp=1/1", ndone, nall); end
        n_cmp++; if (layer_cycles !== 32'd11) begin n_bad++; $display("FAIL single_held got=%0d exp=11", layer_cycles); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_err got=%b exp=0", err); end
    endtask

    task automatic test_five_layers();
        logic [63:0] exp_d [5];
        int exp_c [5];
        exp_d[0] = CONV1_CFG; exp_d[1] = CONV2_CFG; exp_d[2] = CONV3_CFG; exp_d[3] = CONV4_CFG; exp_d[4] = CONV5_CFG;
        exp_c = '{4, 8, 2, 21, 5};
        lat_tab = '{3, 7, 1, 20, 4};
        for (int i = 0; i < 5; i++) write_cfg(3'(i), exp_d[i]);
        run_seq(5);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (obs_bits[i] !== exp_d[i]) begin n_bad++; $display("FAIL five_bits[%0d] got=%h exp=%h", i, obs_bits[i], exp_d[i]); end
            n_cmp++; if (obs_en[i] !== 64) begin n_bad++; $display("FAIL five_scan_en[%0d] got=%0d exp=64", i, obs_en[i]); end
            n_cmp++; if (obs_sidx[i] !== 3'(i)) begin n_bad++; $display("FAIL five_idx[%0d] got=%0d exp=%0d", i, obs_sidx[i], i); end
            n_cmp++; if (obs_cyc[i] !== 32'(exp_c[i])) begin n_bad++; $display("FAIL five_cycles[%0d] got=%0d exp=%0d", i, obs_cyc[i], exp_c[i]); end
        end
        n_cmp++; if (ndone !== 5) begin n_bad++; $display("FAIL five_layer_done got=%0d exp=5", ndone); end
        n_cmp++; if (nall !== 1) begin n_bad++; $display("FAIL five_all_done got=%0d exp=1", nall); end
        n_cmp++; if (layer_idx !== 3'd4) begin n_bad++; $display("FAIL five_idx_hold got=%0d exp=4", layer_idx); end
    endtask

    task automatic test_boundary();
        int en_seen;
        en_seen = 0;
        num_layers = 3'd0;
        run = 1'b1;
        step();
        run = 1'b0;
        n_cmp++; if (all_done !== 1'b1) begin n_bad++; $display("FAIL zero_all_done got=%b exp=1", all_done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy got=%b exp=0", busy); end
        en_seen += int'(scan_en);
        step();
        en_seen += int'(scan_en);
        n_cmp++; if (all_done !== 1'b0) begin n_bad++; $display("FAIL zero_all_done_once got=%b exp=0", all_done); end
        n_cmp++; if (en_seen !== 0 || busy !== 1'b0) begin n_bad++; $display("FAIL zero_idle got scan_en=%0d busy=%b exp=0/0", en_seen, busy); end
        num_layers = 3'd6;
        run = 1'b1;
        step();
        run = 1'b0;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL six_err got=%b exp=1", err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL six_busy got=%b exp=0", busy); end
        step();
        n_cmp++; if (busy !== 1'b0 || err !== 1'b1) begin n_bad++; $display("FAIL six_hold got busy=%b err=%b exp=0/1", busy, err); end
    endtask

    task automatic test_errors();
        lat_tab = '{2, 2, 2, 2, 2};
        write_cfg(3'd2, 64'hA5A5_0F0F_3C3C_9696);
        inj_wr_cycle = 10;
        inj_addr = 3'd2;
        inj_data = '1;
        run_seq(3);
        inj_wr_cycle = -1;
        n_cmp++; if (obs_err5 !== 1'b0) begin n_bad++; $display("FAIL busy_wr_clear got=%b exp=0", obs_err5); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL busy_wr_err got=%b exp=1", err); end
        n_cmp++; if (obs_bits[2] !== 64'hA5A5_0F0F_3C3C_9696) begin n_bad++; $display("FAIL busy_wr_same_run got=%h exp=a5a50f0f3c3c9696", obs_bits[2]); end
        run_seq(3);
        n_cmp++; if (obs_bits[2] !== 64'hA5A5_0F0F_3C3C_9696) begin n_bad++; $display("FAIL busy_wr_rerun got=%h exp=a5a50f0f3c3c9696", obs_bits[2]); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rerun_err got=%b exp=0", err); end
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL idle_done_err got=%b exp=1", err); end
        run_seq(1);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL run_clears_err got=%b exp=0", err); end
        write_cfg(3'd7, '1);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL bad_addr_err got=%b exp=1", err); end
    endtask

    task automatic test_reset_mid();
        lat_tab = '{5, 5, 5, 5, 5};
        inj_rst = 1'b1;
        run_seq(2);
        inj_rst = 1'b0;
        #1;
        n_cmp++; if (rst_hit !== 1'b1) begin n_bad++; $display("FAIL mid_reset_reached got=%b exp=1", rst_hit); end
        n_cmp++; if ({busy, scan_en, scan_data, scan_load, core_start, layer_done, all_done, err} !== 8'h0) begin
            n_bad++; $display("FAIL mid_reset_flags got=%b exp=0", {busy, scan_en, scan_data, scan_load, core_start, layer_done, all_done, err}); end
        n_cmp++; if (layer_idx !== 3'd0 || layer_cycles !== 32'd0) begin
            n_bad++; $display("FAIL mid_reset_regs got idx=%0d cycles=%0d exp=0/0", layer_idx, layer_cycles); end
        step();
        step();
        rst_n = 1'b1;
        step();
        run_seq(2);
        n_cmp++; if (obs_bits[0] !== 64'h0 || obs_bits[1] !== 64'h0) begin
            n_bad++; $display("FAIL mid_reset_cleared got=%h/%h exp=0/0", obs_bits[0], obs_bits[1]); end
        n_cmp++; if (ndone !== 2 || obs_cyc[1] !== 32'd6) begin
            n_bad++; $display("FAIL mid_reset_rerun got done=%0d cycles=%0d exp=2/6", ndone, obs_cyc[1]); end
    endtask

    task automatic test_saturation();
        lat_tab[0] = 20;
        run_seq(1);
        n_cmp++; if (layer_cycles !== 32'd21) begin n_bad++; $display("FAIL sat_wide got=%0d exp=21", layer_cycles); end
        n_cmp++; if (s_layer_cycles !== 4'hF) begin n_bad++; $display("FAIL sat_narrow got=%h exp=f", s_layer_cycles); end
        lat_tab[0] = 13;
        run_seq(1);
        n_cmp++; if (s_layer_cycles !== 4'hE) begin n_bad++; $display("FAIL sat_below got=%h exp=e", s_layer_cycles); end
        lat_tab[0] = 14;
        run_seq(1);
        n_cmp++; if (s_layer_cycles !== 4'hF || layer_cycles !== 32'd15) begin
            n_bad++; $display("FAIL sat_edge got=%h/%0d exp=f/15", s_layer_cycles, layer_cycles); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_five_layers();
        test_boundary();
        test_errors();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
